// File: rtl/mode_select_pkg.sv
// Shared types and constants for the mode-select push-button debouncer.
package mode_select_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 28;

  typedef enum logic [1:0] {
    ST_RELEASED      = 2'd0,
    ST_PRESS_CHECK   = 2'd1,
    ST_PRESSED       = 2'd2,
    ST_RELEASE_CHECK = 2'd3
  } state_t;

  // True on the last required stable cycle; unsigned 28-bit compare, no wrap.
  function automatic logic cnt_done(input logic [CNT_W-1:0] cnt,
                                    input logic [CNT_W-1:0] cycles);
    return (cnt == (cycles - 28'd1));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Metastability synchronizer for the raw button input.
module sync_2ff
  import mode_select_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d_in,
  output logic q_out
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the asynchronous input through the synchronizer stages.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d_in};
    end
  end

  assign q_out = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/mode_select_debouncer.sv
// Debounces a push-button and toggles the clock-divider mode once per accepted press.
module mode_select_debouncer
  import mode_select_pkg::*;
#(
  parameter logic [27:0] DEBOUNCE_CYCLES = 28'd1000000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic btn_in,
  output logic mode_out,
  output logic btn_level_out,
  output logic press_pulse_out
);

  logic             btn_s;
  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             mode_r, mode_s;
  logic             level_r, level_s;
  logic             pulse_r, pulse_s;

  sync_2ff u_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d_in     (btn_in),
    .q_out    (btn_s)
  );

  // Next-state, counter and output decisions for the debounce FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    mode_s  = mode_r;
    level_s = level_r;
    pulse_s = 1'b0;
    case (state_r)
      ST_RELEASED: begin
        if (btn_s) begin
          state_s = ST_PRESS_CHECK;
          cnt_s   = 28'd0;
        end else begin
          state_s = ST_RELEASED;
        end
      end
      ST_PRESS_CHECK: begin
        if (!btn_s) begin
          state_s = ST_RELEASED;
          cnt_s   = 28'd0;
        end else if (cnt_done(cnt_r, DEBOUNCE_CYCLES)) begin
          state_s = ST_PRESSED;
          level_s = 1'b1;
          pulse_s = 1'b1;
          mode_s  = ~mode_r;
        end else begin
          cnt_s = cnt_r + 28'd1;
        end
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          state_s = ST_RELEASE_CHECK;
          cnt_s   = 28'd0;
        end else begin
          state_s = ST_PRESSED;
        end
      end
      ST_RELEASE_CHECK: begin
        // A bounce back high returns to PRESSED silently: no pulse, no toggle.
        if (btn_s) begin
          state_s = ST_PRESSED;
          cnt_s   = 28'd0;
        end else if (cnt_done(cnt_r, DEBOUNCE_CYCLES)) begin
          state_s = ST_RELEASED;
          level_s = 1'b0;
        end else begin
          cnt_s = cnt_r + 28'd1;
        end
      end
      default: begin
        state_s = ST_RELEASED;
        cnt_s   = 28'd0;
      end
    endcase
  end

  // State, counter and registered outputs; reset wins over any transition.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_r <= ST_RELEASED;
      cnt_r   <= 28'd0;
      mode_r  <= 1'b0;
      level_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      mode_r  <= mode_s;
      level_r <= level_s;
      pulse_r <= pulse_s;
    end
  end

  assign mode_out        = mode_r;
  assign btn_level_out   = level_r;
  assign press_pulse_out = pulse_r;

endmodule
